// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the VeriRISC memory arbiter.
// Imported by mem_arb and mem_arb_pick.
package mem_arb_pkg;

    localparam int ARB_AWIDTH = 5;
    localparam int ARB_DWIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational CPU-first arbitration with a debug anti-starvation override.
// Debug wins a contended cycle once it has lost MAX_WAIT in a row.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WW       = 3
) (
    input  logic          cpu_req,
    input  logic          dbg_req,
    input  logic [WW-1:0] wait_cnt,
    output arb_owner_e    winner,
    output logic          valid
);

    logic starved;

    always_comb begin
        valid   = cpu_req | dbg_req;
        starved = (wait_cnt == WW'(MAX_WAIT));
        winner  = OWN_CPU;
        unique case (1'b1)
            (dbg_req & ~cpu_req): winner = OWN_DBG;
            (dbg_req & starved):  winner = OWN_DBG;
            default:              winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port (CPU/debug) arbiter and access sequencer for the VeriRISC memory.
// Optional MEM_ARB_STATS_EN adds per-port ack counters and a starve_hit pulse.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH   = ARB_AWIDTH,
    parameter int DWIDTH   = ARB_DWIDTH,
    parameter int ACC_CYC  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DWIDTH-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_cnt,
    output logic [15:0]       dbg_cnt,
    output logic              starve_hit
`endif
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, win;
    logic              win_vld;
    logic              we_q;
    logic [WW-1:0]     wait_cnt;
    logic [CW-1:0]     acc_cnt;
    logic              grant, last;
    logic              sel_we;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WW       (WW)
    ) u_pick (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .wait_cnt (wait_cnt),
        .winner   (win),
        .valid    (win_vld)
    );

    always_comb begin
        sel_we    = (win == OWN_DBG) ? dbg_we    : cpu_we;
        sel_addr  = (win == OWN_DBG) ? dbg_addr  : cpu_addr;
        sel_wdata = (win == OWN_DBG) ? dbg_wdata : cpu_wdata;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        last    = (acc_cnt == CW'(ACC_CYC - 1));
        unique case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    grant   = 1'b1;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (last) state_d = ARB_RESP;
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            owner_q   <= OWN_CPU;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            acc_cnt   <= '0;
            cpu_gnt   <= 1'b0;
            dbg_gnt   <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    acc_cnt <= '0;
                    // Count only CPU wins that actually made debug wait
                    if (!dbg_req || (grant && win == OWN_DBG))
                        wait_cnt <= '0;
                    else if (grant && wait_cnt != WW'(MAX_WAIT))
                        wait_cnt <= wait_cnt + 1'b1;
                    if (grant) begin
                        owner_q   <= win;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= ~sel_we;
                        mem_wr    <= sel_we;
                        cpu_gnt   <= (win == OWN_CPU);
                        dbg_gnt   <= (win == OWN_DBG);
                    end
                end
                ARB_ACCESS: begin
                    acc_cnt <= acc_cnt + 1'b1;
                    if (last) begin
                        acc_cnt <= '0;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        cpu_ack <= (owner_q == OWN_CPU);
                        dbg_ack <= (owner_q == OWN_DBG);
                        if (!we_q && owner_q == OWN_CPU) cpu_rdata <= mem_rdata;
                        if (!we_q && owner_q == OWN_DBG) dbg_rdata <= mem_rdata;
                    end
                end
                ARB_RESP: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    cpu_gnt <= 1'b0;
                    dbg_gnt <= 1'b0;
                end
                default: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cpu_cnt    <= '0;
            dbg_cnt    <= '0;
            starve_hit <= 1'b0;
        end else begin
            if (cpu_ack) cpu_cnt <= cpu_cnt + 16'd1;
            if (dbg_ack) dbg_cnt <= dbg_cnt + 16'd1;
            // Debug beating a live CPU request can only be the wait rule
            starve_hit <= grant && (win == OWN_DBG) && cpu_req;
        end
    end
`endif

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-port arbiter and sequencer for the single VeriRISC memory.
- Shares the memory between the CPU (fetch/operand/store traffic raised by the control unit) and a debug/loader port (program load, memory inspection).
- Owns every mem_rd/mem_wr/mem_addr strobe to the memory and returns read data with a one-cycle ack to the winning requester.
- CPU has priority. A wait counter guarantees the debug port cannot starve.

Parameters:
- AWIDTH, 5, address width (32-word memory).
- DWIDTH, 8, data width.
- ACC_CYC, 2, cycles mem_rd/mem_wr are held per access (min 1).
- MAX_WAIT, 4, consecutive lost arbitrations after which debug wins (min 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_  in  1  reset, asynchronous, active low.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req.
- cpu_addr  in  AWIDTH  CPU address.
- cpu_wdata  in  DWIDTH  CPU write data.
- cpu_gnt  out  1  high from access start through ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DWIDTH  read data, valid with cpu_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_ack, dbg_rdata: same as cpu_*, for the debug port.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data, valid one cycle after mem_rd rises.

Behaviour:
- Reset (rst_=0, any time, including mid-access):
  - State goes to IDLE.
  - All gnt/ack/mem_rd/mem_wr outputs go to 0.
  - mem_addr, mem_wdata, cpu_rdata and dbg_rdata go to 0.
  - wait_cnt goes to 0.
  - An interrupted access is dropped and no ack is issued.
- All outputs are registered.
- States:
  - IDLE: arbitrate.
    - Nothing requested: stay in IDLE.
    - Otherwise latch owner, we, addr and wdata from the winner, assert its gnt, go to ACCESS.
  - ACCESS: hold mem_rd=~we and mem_wr=we, with mem_addr/mem_wdata from the latched values, for exactly ACC_CYC cycles (acc_cnt counts 0..ACC_CYC-1). On the last cycle, capture mem_rdata into the owner's rdata register for reads, then go to RESP.
  - RESP: mem_rd and mem_wr are 0. The owner's ack is 1 for exactly this cycle; gnt stays 1. Next state is IDLE.
- gnt drops on entry to IDLE. Minimum spacing between accesses is ACC_CYC+2 cycles.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: CPU wins unless wait_cnt==MAX_WAIT, in which case debug wins.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each time the CPU wins while dbg_req=1.
  - Clears when debug is granted or when dbg_req=0 in IDLE.
- The non-owner's rdata register holds its previous value. The owner's rdata is unchanged on writes.
- A request dropped during ACCESS/RESP does not abort the access; it completes and ack is still pulsed.
- Request inputs are sampled only in IDLE. Changes to we/addr/wdata after grant are ignored.
- Simultaneous write and read to the same address from different ports: strictly serialized in grant order, with no forwarding.
- One-hot check: mem_rd and mem_wr are never both 1, and at most one gnt is 1.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs cpu_cnt and dbg_cnt (16 bits each, reset 0). Each increments on its port's ack and wraps from 16'hFFFF to 0. Adds output starve_hit, a one-cycle pulse when debug wins by the wait_cnt rule.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e.
  - typedef enum logic {OWN_CPU, OWN_DBG} arb_owner_e.
  - Default width constants matching the CPU's AWIDTH=5 and DWIDTH=8.
- One sub-module, mem_arb_pick: combinational priority/starvation decision from cpu_req, dbg_req and wait_cnt, producing the winner and a valid flag.
- State, counters and registered outputs stay in mem_arb.

Test Plan:
- CPU read addr 5'h0A, memory holds 8'h3C: mem_rd high for 2 cycles, cpu_ack pulses once, cpu_rdata=8'h3C with ack, dbg_* outputs stay 0.
- Debug write addr 5'h1F, data 8'hA5, then CPU read 5'h1F: mem_wr for 2 cycles, dbg_ack pulses, then cpu_rdata=8'hA5.
- CPU and debug both held high continuously (MAX_WAIT=4): grant order CPU,CPU,CPU,CPU,DBG repeating; wait_cnt returns to 0 after each debug grant.
- rst_ driven low in the 2nd ACCESS cycle: mem_rd, gnt and ack go to 0 immediately, no ack after rst_ rises; the next request proceeds normally from IDLE.
- cpu_req dropped during ACCESS: access completes, cpu_ack still pulses once, and the arbiter then returns to IDLE.
- With MEM_ARB_STATS_EN, 3 CPU reads and 2 debug writes: cpu_cnt=3, dbg_cnt=2, starve_hit never pulses.
